// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types and default constants for the fetch unit,
// the hazard unit and the top level.
package mips_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch port: request/grant handshake plus in-order read data return.
interface pc_fetch_unit_if;

  // A request transfers when req && gnt are high on the same posedge. The
  // master holds req and addr steady until then. Exactly one rvalid comes
  // back per accepted request, at least one cycle later, in order.
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched word and its PC while ID is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_data;
  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the architectural PC, issues one outstanding imem request at a
// time, and loads the IF/ID register, honouring redirects and ID stalls.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              npc,
  input  logic                     stall,
  pc_fetch_unit_if.master          imem,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_pc_plus4,
  output logic                     fetch_misalign,
  output fetch_state_t             o_dbg_state
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_pc_plus4;
  logic         r_misalign;

  logic         w_redir_eff;
  logic         w_rd_take;
  logic         w_in_hold;
  logic         w_hold_load;
  logic         w_hold_clr;
  logic         w_load_ifid;
  logic         w_hold_valid;
  logic [31:0]  w_hold_data;
  logic [31:0]  w_hold_pc;
  logic [31:0]  w_load_data;
  logic [31:0]  w_load_pc;

  // A stalled ID cannot accept a new stream, so stall masks redirect.
  assign w_redir_eff = redirect & ~stall;
  assign w_rd_take   = (r_state == S_WAIT) & imem.rvalid;
  assign w_in_hold   = (r_state == S_HOLD);
  assign w_hold_load = w_rd_take & stall;
  assign w_hold_clr  = w_in_hold & ~stall;
  assign w_load_ifid = ~stall & ~w_redir_eff &
                       (w_rd_take | (w_in_hold & w_hold_valid));
  assign w_load_data = w_in_hold ? w_hold_data : imem.rdata;
  assign w_load_pc   = w_in_hold ? w_hold_pc : r_pc;

  fetch_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clr),
    .i_data  (imem.rdata),
    .i_pc    (r_pc),
    .o_valid (w_hold_valid),
    .o_data  (w_hold_data),
    .o_pc    (w_hold_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= NOP_INSTR;
      r_if_pc       <= RESET_PC;
      r_if_pc_plus4 <= RESET_PC + 32'd4;
      r_misalign    <= 1'b0;
    end else begin
      r_misalign <= w_redir_eff & (npc[1:0] != 2'b00);

      if (w_redir_eff) begin
        r_pc <= word_align(npc);
      end else if (w_load_ifid) begin
        r_pc <= w_load_pc + 32'd4;
      end

      if (!stall) begin
        if (w_load_ifid) begin
          r_if_valid    <= 1'b1;
          r_if_instr    <= w_load_data;
          r_if_pc       <= w_load_pc;
          r_if_pc_plus4 <= w_load_pc + 32'd4;
        end else begin
          r_if_valid <= 1'b0;
          r_if_instr <= NOP_INSTR;
        end
      end

      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          // A redirect in the grant cycle leaves a stale request in flight.
          if (imem.gnt) r_state <= w_redir_eff ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            if (w_redir_eff)  r_state <= S_REQ;
            else if (stall)   r_state <= S_HOLD;
            else              r_state <= S_REQ;
          end else if (w_redir_eff) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (imem.rvalid) r_state <= S_REQ;
        end
        S_HOLD: begin
          if (!stall) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem.req       = (r_state == S_REQ);
  assign imem.addr      = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;
  assign if_pc_plus4    = r_if_pc_plus4;
  assign fetch_misalign = r_misalign;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory responder plus an instruction-stream reference
// model (expected PC sequence, redirects, stall holds), directed cases then random traffic.
module tb_pc_fetch_unit;
  import mips_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         redirect;
  logic [31:0]  npc;
  logic         stall;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic [31:0]  if_pc_plus4;
  logic         fetch_misalign;
  fetch_state_t dbg_state;

  pc_fetch_unit_if imem ();

  pc_fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .npc            (npc),
    .stall          (stall),
    .imem           (imem),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fetch_misalign (fetch_misalign),
    .o_dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired, required finish before 2000000");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];      // expected request addresses in directed cases
  logic [31:0] pend_addr[$];  // accepted requests awaiting rvalid
  int          pend_due[$];
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          stray_rv = 0;

  logic [31:0] exp_pc = RPC;
  logic [31:0] last_pc = '0;
  int          deliv = 0;
  int          last_deliv = 0;
  bit          chk_gap = 0;
  bit          track_req = 0;
  bit          granted = 0;
  logic [31:0] g_addr = '0;
  bit          seen_req = 0;
  logic [31:0] seen_addr = '0;

  bit          p_rst, p_stall, p_redir;
  logic [31:0] p_npc;
  bit          s_valid;
  logic [31:0] s_instr, s_pc;
  bit          n_req_wait = 0;
  logic [31:0] n_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- one clock cycle: respond, sample, model ----------------
  task automatic tick();
    if (stray_rv) begin
      imem.rvalid = 1'b1;
      imem.rdata  = 32'hDEAD_BEEF;
      stray_rv    = 0;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem.rvalid = 1'b1;
      imem.rdata  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem.rvalid = 1'b0;
      imem.rdata  = $urandom;
    end

    @(negedge clk);
    granted  = 0;
    seen_req = imem.req;
    seen_addr = imem.addr;
    if (n_req_wait) begin
      check_eq("req_held", 32'(imem.req), 32'd1);
      check_eq("addr_stable", imem.addr, n_addr);
    end
    if (imem.req === 1'b1) check_eq("addr_align", 32'(imem.addr[1:0]), 32'd0);
    if (imem.req === 1'b1 && imem.gnt === 1'b1 && !rst) begin
      granted = 1;
      g_addr  = imem.addr;
      pend_addr.push_back(imem.addr);
      pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
      if (track_req && exp_q.size() > 0) check_eq("req_addr", imem.addr, exp_q.pop_front());
    end
    n_req_wait = (imem.req === 1'b1) && !imem.gnt && !(redirect && !stall) && !rst;
    n_addr     = imem.addr;
    p_rst   = rst;
    p_stall = stall;
    p_redir = redirect && !stall;
    p_npc   = npc;
    s_valid = if_valid;
    s_instr = if_instr;
    s_pc    = if_pc;

    @(posedge clk);
    #1;
    if (p_rst) begin
      check_eq("rst_if_valid", 32'(if_valid), 32'd0);
      check_eq("rst_if_instr", if_instr, NOP);
      check_eq("rst_if_pc", if_pc, RPC);
      check_eq("rst_if_pc4", if_pc_plus4, RPC + 32'd4);
      check_eq("rst_req", 32'(imem.req), 32'd0);
      check_eq("rst_misalign", 32'(fetch_misalign), 32'd0);
      exp_pc = RPC;
      pend_addr.delete();
      pend_due.delete();
      n_req_wait = 0;
    end else begin
      check_eq("misalign", 32'(fetch_misalign), 32'(p_redir && (p_npc[1:0] != 2'b00)));
      if (p_stall) begin
        check_eq("stall_valid", 32'(if_valid), 32'(s_valid));
        check_eq("stall_instr", if_instr, s_instr);
        check_eq("stall_pc", if_pc, s_pc);
      end else if (p_redir) begin
        check_eq("flush_valid", 32'(if_valid), 32'd0);
        exp_pc = {p_npc[31:2], 2'b00};
      end else if (if_valid) begin
        check_eq("deliv_pc", if_pc, exp_pc);
        check_eq("deliv_instr", if_instr, mem_word(exp_pc));
        if (chk_gap && deliv > 0) check_eq("deliv_gap", 32'(cyc - last_deliv), 32'd2);
        last_deliv = cyc;
        last_pc    = if_pc;
        deliv++;
        exp_pc = exp_pc + 32'd4;
      end
      if (!if_valid) check_eq("bubble_nop", if_instr, NOP);
      check_eq("pc_plus4", if_pc_plus4, if_pc + 32'd4);
    end
    cyc++;
  endtask

  task automatic wait_grant(input string tag);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (granted) break;
    end
    check_eq(tag, 32'(granted), 32'd1);
  endtask

  task automatic wait_deliv(input string tag);
    int d0;
    d0 = deliv;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (deliv > d0) break;
    end
    check_eq(tag, 32'(deliv > d0), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d_rand;
    rst = 1'b1; redirect = 1'b0; npc = '0; stall = 1'b0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
    repeat (2) tick();
    rst = 1'b0;

    // sequential fetch with 1-cycle memory
    deliv = 0; chk_gap = 1; track_req = 1; imem.gnt = 1'b1;
    exp_q.push_back(32'h3000); exp_q.push_back(32'h3004); exp_q.push_back(32'h3008);
    repeat (8) tick();
    check_eq("seq_req_all", 32'(exp_q.size()), 32'd0);
    check_eq("seq_deliv_cnt", 32'(deliv), 32'd3);
    chk_gap = 0;

    // redirect while waiting on a slow response
    lat_min = 3; lat_max = 3;
    wait_grant("wait_grant_redir");
    redirect = 1'b1; npc = 32'h3100;
    tick();
    redirect = 1'b0;
    exp_q.delete(); exp_q.push_back(32'h3100);
    wait_deliv("redir_deliv");
    check_eq("redir_first_pc", last_pc, 32'h3100);
    check_eq("redir_req_seen", 32'(exp_q.size()), 32'd0);

    // response arrives under a 3-cycle stall
    lat_min = 1; lat_max = 1;
    wait_grant("wait_grant_stall");
    begin
      logic [31:0] held_pc;
      held_pc = g_addr;
      stall = 1'b1;
      repeat (3) tick();
      stall = 1'b0;
      wait_deliv("stall_deliv");
      check_eq("stall_release_pc", last_pc, held_pc);
    end

    // redirect masked by stall, then a misaligned redirect
    stall = 1'b1; redirect = 1'b1; npc = 32'h5000;
    tick();
    stall = 1'b0; redirect = 1'b0;
    repeat (3) tick();
    redirect = 1'b1; npc = 32'h3102;
    tick();
    redirect = 1'b0;
    exp_q.delete(); exp_q.push_back(32'h3100);
    wait_deliv("misalign_deliv");
    check_eq("misalign_first_pc", last_pc, 32'h3100);

    // grant withheld for 4 cycles
    imem.gnt = 1'b0;
    for (int i = 0; i < 10 && !seen_req; i++) tick();
    begin
      logic [31:0] a0;
      a0 = seen_addr;
      check_eq("gnt0_req_seen", 32'(seen_req), 32'd1);
      for (int i = 0; i < 4; i++) begin
        tick();
        check_eq("gnt0_req", 32'(seen_req), 32'd1);
        check_eq("gnt0_addr", seen_addr, a0);
      end
    end
    imem.gnt = 1'b1;
    track_req = 0;

    // reset while a request is outstanding, late rvalid lands in idle
    lat_min = 3; lat_max = 3;
    wait_grant("wait_grant_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stray_rv = 1;
    tick();
    check_eq("stray_ignored", 32'(if_valid), 32'd0);
    wait_deliv("post_rst_deliv");
    check_eq("post_rst_pc", last_pc, RPC);

    // randomized traffic
    lat_min = 1; lat_max = 3;
    d_rand = deliv;
    for (int i = 0; i < 2000; i++) begin
      imem.gnt = ($urandom_range(0, 9) < 7);
      stall    = ($urandom_range(0, 9) < 2);
      redirect = ($urandom_range(0, 9) < 1);
      case ($urandom_range(0, 3))
        0: npc = 32'h3000 + ($urandom_range(0, 63) << 2);
        1: npc = 32'h3000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
        2: npc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
        default: npc = $urandom;
      endcase
      tick();
    end
    stall = 1'b0; redirect = 1'b0; imem.gnt = 1'b1;
    repeat (10) tick();
    check_eq("rand_progress", 32'(deliv - d_rand > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
